// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
// Module   : note_player
// Function : Turns a MIDI note level (60..72) into a square-wave sample stream
//            with a linear attack/sustain/release envelope. Defining
//            NOTE_PLAYER_ENVELOPE_EN enables the ramps; otherwise notes switch
//            straight to full amplitude and back to silence.
// Revision : 1.0 - initial release
// ============================================================================
module note_player #(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int AMP_MAX    = 127,
    parameter int RAMP_DIV   = 1024
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] note_in,
    output logic [7:0] audio_out,
    output logic       playing_out,
    output logic [7:0] active_note_out
);

    typedef logic [15:0][23:0] half_tab_t;

    // 2^(k/12) for k = n - 69 over the supported range
    function automatic real semitone_ratio(input int k);
        real r;
        case (k)
            -9:      r = 0.5946035575013605;
            -8:      r = 0.6299605249474366;
            -7:      r = 0.6674199270850172;
            -6:      r = 0.7071067811865476;
            -5:      r = 0.7491535384383408;
            -4:      r = 0.7937005259840998;
            -3:      r = 0.8408964152537145;
            -2:      r = 0.8908987181403393;
            -1:      r = 0.9438743126816935;
            1:       r = 1.0594630943592953;
            2:       r = 1.1224620483093730;
            3:       r = 1.1892071150027210;
            default: r = 1.0;
        endcase
        return r;
    endfunction

    function automatic half_tab_t build_half_tab();
        half_tab_t tab;
        tab = '0;
        for (int i = 0; i <= 12; i++) begin
            tab[i] = 24'($rtoi(real'(SYS_CLK_HZ) / (880.0 * semitone_ratio(i - 9)) + 0.5));
        end
        return tab;
    endfunction

    localparam half_tab_t  HALF_TAB = build_half_tab();
    localparam logic [6:0] AMP_TOP  = 7'(AMP_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  note_q;
    logic [6:0]  amp, amp_nx;
    logic [23:0] half, half_nx;
    logic [23:0] cnt, cnt_nx;
    logic        phase, phase_nx;
    logic [7:0]  active_nx;
    logic [7:0]  audio_nx;
    logic [23:0] tab_half;
    logic        supported;
    logic        load;

`ifdef NOTE_PLAYER_ENVELOPE_EN
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [RW-1:0] ramp, ramp_nx;
    logic          tick;
`endif

    always_comb begin
        supported = (note_q >= 8'd60) && (note_q <= 8'd72);
        tab_half  = HALF_TAB[4'(note_q - 8'd60)];
        state_nx  = state;
        amp_nx    = amp;
        half_nx   = half;
        cnt_nx    = cnt;
        phase_nx  = phase;
        active_nx = active_note_out;
        load      = 1'b0;
`ifdef NOTE_PLAYER_ENVELOPE_EN
        ramp_nx   = ramp;
        tick      = (ramp == RW'(RAMP_DIV - 1));
        case (state)
            IDLE: begin
                if (supported) begin
                    state_nx = ATTACK;
                    load     = 1'b1;
                    ramp_nx  = '0;
                end
            end
            ATTACK, SUSTAIN: begin
                if (!supported) begin
                    state_nx = RELEASE;
                    ramp_nx  = '0;
                end else begin
                    load = (note_q != active_note_out);
                    if (state == ATTACK) begin
                        if (amp == AMP_TOP) begin
                            state_nx = SUSTAIN;
                        end else begin
                            ramp_nx = tick ? '0 : ramp + 1'b1;
                            if (tick) begin
                                amp_nx = amp + 7'd1;
                                if (amp_nx == AMP_TOP) state_nx = SUSTAIN;
                            end
                        end
                    end
                end
            end
            RELEASE: begin
                if (supported) begin
                    state_nx = ATTACK;
                    load     = 1'b1;
                    ramp_nx  = '0;
                end else if (amp == 7'd0) begin
                    state_nx = IDLE;
                end else begin
                    ramp_nx = tick ? '0 : ramp + 1'b1;
                    if (tick) begin
                        amp_nx = amp - 7'd1;
                        if (amp_nx == 7'd0) state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
`else
        case (state)
            IDLE, RELEASE: begin
                if (supported) begin
                    state_nx = SUSTAIN;
                    amp_nx   = AMP_TOP;
                    load     = 1'b1;
                end
            end
            ATTACK, SUSTAIN: begin
                if (!supported) begin
                    state_nx = IDLE;
                    amp_nx   = 7'd0;
                end else begin
                    load = (note_q != active_note_out);
                end
            end
            default: state_nx = IDLE;
        endcase
`endif
        // Square wave restarts high on every pitch load and is frozen while idle
        if (load) begin
            half_nx   = tab_half;
            cnt_nx    = '0;
            phase_nx  = 1'b1;
            active_nx = note_q;
        end else if (state != IDLE) begin
            if (cnt >= half - 24'd1) begin
                cnt_nx   = '0;
                phase_nx = ~phase;
            end else begin
                cnt_nx = cnt + 24'd1;
            end
        end
        if (state_nx == IDLE) active_nx = '0;
        audio_nx = phase_nx ? (8'd128 + {1'b0, amp_nx}) : (8'd128 - {1'b0, amp_nx});
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= IDLE;
            note_q          <= '0;
            amp             <= '0;
            half            <= '0;
            cnt             <= '0;
            phase           <= 1'b0;
            active_note_out <= '0;
            audio_out       <= 8'd128;
`ifdef NOTE_PLAYER_ENVELOPE_EN
            ramp            <= '0;
`endif
        end else begin
            state           <= state_nx;
            note_q          <= note_in;
            amp             <= amp_nx;
            half            <= half_nx;
            cnt             <= cnt_nx;
            phase           <= phase_nx;
            active_note_out <= active_nx;
            audio_out       <= audio_nx;
`ifdef NOTE_PLAYER_ENVELOPE_EN
            ramp            <= ramp_nx;
`endif
        end
    end

    assign playing_out = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_note_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_player
// Function : Randomised + directed stimulus for note_player, checked every
//            cycle against a time-based behavioural model through a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_player;

    localparam int SYS_HZ = 88_000;
    localparam int AMAX   = 8;
    localparam int RDIV   = 4;
`ifdef NOTE_PLAYER_ENVELOPE_EN
    localparam bit ENV = 1'b1;
`else
    localparam bit ENV = 1'b0;
`endif
    localparam int S_IDLE = 0, S_ATT = 1, S_SUS = 2, S_REL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] note_in = 8'd0;
    logic [7:0] audio_out;
    logic       playing_out;
    logic [7:0] active_note_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [16:0] exp_q[$];

    note_player #(
        .SYS_CLK_HZ(SYS_HZ),
        .AMP_MAX   (AMAX),
        .RAMP_DIV  (RDIV)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .note_in        (note_in),
        .audio_out      (audio_out),
        .playing_out    (playing_out),
        .active_note_out(active_note_out)
    );

    always #5 clk = ~clk;

    function automatic int half_of(input int n);
        real f;
        f = 440.0 * (2.0 ** (real'(n - 69) / 12.0));
        return $rtoi(real'(SYS_HZ) / (2.0 * f) + 0.5);
    endfunction

    // Reference model: phase is derived from time elapsed since the last pitch load
    int m_st = S_IDLE, m_amp = 0, m_t = 0, m_half = 1, m_act = 0, m_nq = 0, m_rk = 0;
    int prev;
    bit sup, load, hi;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = S_IDLE; m_amp = 0; m_t = 0; m_half = 1; m_act = 0; m_nq = 0; m_rk = 0;
            exp_q.delete();
            exp_q.push_back({8'd128, 1'b0, 8'd0});
        end else begin
            sup  = (m_nq >= 60) && (m_nq <= 72);
            load = 1'b0;
            prev = m_st;
            if (ENV) begin
                case (m_st)
                    S_IDLE: if (sup) begin m_st = S_ATT; load = 1'b1; m_rk = 0; end
                    S_ATT, S_SUS: begin
                        if (!sup) begin
                            m_st = S_REL; m_rk = 0;
                        end else begin
                            load = (m_nq != m_act);
                            if (m_st == S_ATT) begin
                                if (m_amp == AMAX) m_st = S_SUS;
                                else begin
                                    m_rk++;
                                    if (m_rk % RDIV == 0) m_amp++;
                                    if (m_amp == AMAX) m_st = S_SUS;
                                end
                            end
                        end
                    end
                    default: begin
                        if (sup) begin m_st = S_ATT; load = 1'b1; m_rk = 0; end
                        else if (m_amp == 0) m_st = S_IDLE;
                        else begin
                            m_rk++;
                            if (m_rk % RDIV == 0) m_amp--;
                            if (m_amp == 0) m_st = S_IDLE;
                        end
                    end
                endcase
            end else begin
                if (m_st == S_IDLE && sup) begin
                    m_st = S_SUS; m_amp = AMAX; load = 1'b1;
                end else if (m_st != S_IDLE && !sup) begin
                    m_st = S_IDLE; m_amp = 0;
                end else if (m_st != S_IDLE) begin
                    load = (m_nq != m_act);
                end
            end
            if (load) begin
                m_half = half_of(m_nq); m_t = 0; m_act = m_nq;
            end else if (prev != S_IDLE) begin
                m_t++;
            end
            if (m_st == S_IDLE) m_act = 0;
            m_nq = int'(note_in);
            hi = ((m_t / m_half) % 2) == 0;
            exp_q.push_back({8'(hi ? 128 + m_amp : 128 - m_amp), m_st != S_IDLE, 8'(m_act)});
        end
    end

    logic [16:0] e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({audio_out, playing_out, active_note_out} !== e) begin
                miscompares++;
                $display("FAIL sample t=%0t: audio=%0d playing=%0b note=%0d, expected audio=%0d playing=%0b note=%0d",
                         $time, audio_out, playing_out, active_note_out, e[16:9], e[8], e[7:0]);
            end
        end
    end

    task automatic apply(input int n, input int cyc);
        note_in = 8'(n);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #5 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int dn[] = '{69, 72, 0, 50, 60, 0, 60, 0, 60, 0, 69, 0, 69, 0, 69, 72, 60, 0};
    int dc[] = '{300, 200, 50, 20, 60, 13, 60, 1, 30, 50, 1, 10, 3, 40, 50, 7, 80, 60};
    int r;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < dn.size(); i++) apply(dn[i], dc[i]);
        apply(69, 120);
        pulse_reset();
        apply(69, 80);
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)       note_in = 8'd0;
            else if (r == 3) note_in = 8'($urandom_range(0, 255));
            else             note_in = 8'(60 + $urandom_range(0, 12));
            apply(int'(note_in), int'($urandom_range(1, 45)));
            if ($urandom_range(0, 39) == 0) pulse_reset();
        end
        apply(0, 60);
        if (vectors < 1000) begin
            miscompares++;
            $display("FAIL vector-count: got %0d, need at least 1000", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
